// File: rtl/multi_buffer_swap_ctrl_pkg.sv
// Shared types for the N-way frame buffer swap controller: presentation modes,
// per-buffer ownership codes and the producer/consumer state encodings.
package multi_buffer_swap_ctrl_pkg;

  localparam int MODE_FIFO   = 0;
  localparam int MODE_LATEST = 1;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_READY = 2'd2,
    ST_DISP  = 2'd3
  } buf_state_e;

  // P_IDLE: waiting for a free buffer | P_REQ: grant offered | P_DRAW: producer drawing
  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_REQ  = 2'd1,
    P_DRAW = 2'd2
  } prod_state_e;

  // C_IDLE: nothing offered to display | C_REQ: swap pending until swap_ack
  typedef enum logic {
    C_IDLE = 1'b0,
    C_REQ  = 1'b1
  } cons_state_e;

endpackage

// File: rtl/multi_buffer_swap_ctrl_ready_queue.sv
// Ordered queue of READY buffer indices, oldest at entry 0. Supports one push
// and a multi-entry pop in the same cycle; the push lands behind the survivors.
module swap_ready_queue #(
  parameter int DEPTH = 3,
  parameter int BW    = 2,
  parameter int CW    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [BW-1:0]             push_idx_i,
  input  logic [CW-1:0]             pop_n_i,
  output logic [BW-1:0]             head_o,
  output logic [BW-1:0]             newest_o,
  output logic [CW-1:0]             count_o,
  output logic [DEPTH-1:0][BW-1:0]  entries_o
);

  logic [DEPTH-1:0][BW-1:0] mem_q, mem_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) == pop_n_i) && (i + k < DEPTH)) mem_d[i] = mem_q[i + k];
      end
    end
    cnt_d = cnt_q - pop_n_i;
    if (push_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_d) mem_d[i] = push_idx_i;
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    newest_o = mem_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == cnt_q) newest_o = mem_q[i];
    end
  end

  assign head_o    = mem_q[0];
  assign count_o   = cnt_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/multi_buffer_swap_ctrl.sv
// N-way frame buffer swap controller: hands buffers to the renderer, queues
// finished frames and presents them to scan-out in FIFO or LATEST order.
module multi_buffer_swap_ctrl
  import multi_buffer_swap_ctrl_pkg::*;
#(
  parameter int NUM_BUFS    = 3,
  parameter int MODE        = MODE_FIFO,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int BW         = $clog2(NUM_BUFS)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             swap,
  output logic [BW-1:0]    swap_buf,
  input  logic             swap_ack,
  output logic [BW-1:0]    front_buf,
  output logic             bg_start,
  output logic [BW-1:0]    bg_buf,
  input  logic             bg_start_ack,
  input  logic             bg_done,
  output logic             bg_done_ack,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             protocol_err
);

  localparam int CW = $clog2(NUM_BUFS + 1);
  localparam int SW = CNT_W + 1;

  buf_state_e  st_q [NUM_BUFS];
  buf_state_e  st_d [NUM_BUFS];
  prod_state_e p_q, p_d;
  cons_state_e c_q, c_d;

  logic [BW-1:0]          bg_buf_q, bg_buf_d;
  logic [BW-1:0]          swap_buf_q, swap_buf_d;
  logic [BW-1:0]          front_q, front_d;
  logic [CW-1:0]          pop_n_q, pop_n_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_d_q;
  logic [CNT_W-1:0]       fc_q, fc_d, dc_q, dc_d;
  logic                   perr_q, perr_d;

  logic                      done_edge;
  logic                      any_free;
  logic [BW-1:0]             free_idx;
  logic                      q_push;
  logic [CW-1:0]             q_pop_n;
  logic [BW-1:0]             q_head, q_newest;
  logic [CW-1:0]             q_count;
  logic [NUM_BUFS-1:0][BW-1:0] q_entries;
  logic [SW-1:0]             dc_sum;

  assign done_edge = sync_q[SYNC_STAGES-1] & ~ack_d_q;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        any_free = 1'b1;
        free_idx = BW'(i);
      end
    end
  end

  swap_ready_queue #(
    .DEPTH (NUM_BUFS),
    .BW    (BW),
    .CW    (CW)
  ) u_ready_queue (
    .clock      (clock),
    .reset      (reset),
    .push_i     (q_push),
    .push_idx_i (bg_buf_q),
    .pop_n_i    (q_pop_n),
    .head_o     (q_head),
    .newest_o   (q_newest),
    .count_o    (q_count),
    .entries_o  (q_entries)
  );

  always_comb begin
    p_d        = p_q;
    c_d        = c_q;
    st_d       = st_q;
    bg_buf_d   = bg_buf_q;
    swap_buf_d = swap_buf_q;
    front_d    = front_q;
    pop_n_d    = pop_n_q;
    fc_d       = fc_q;
    dc_d       = dc_q;
    perr_d     = perr_q;
    q_push     = 1'b0;
    q_pop_n    = '0;
    dc_sum     = '0;

    // The granted buffer is reserved as DRAW while the grant is still offered.
    case (p_q)
      P_IDLE: if (any_free) begin
        bg_buf_d       = free_idx;
        st_d[free_idx] = ST_DRAW;
        p_d            = P_REQ;
      end
      P_REQ:  if (bg_start_ack) p_d = P_DRAW;
      P_DRAW: if (done_edge) begin
        st_d[bg_buf_q] = ST_READY;
        q_push         = 1'b1;
        p_d            = P_IDLE;
      end
      default: p_d = P_IDLE;
    endcase

    if (done_edge && (p_q != P_DRAW)) perr_d = 1'b1;

    // pop_n is fixed at request time so frames queued during the wait survive.
    case (c_q)
      C_IDLE: if (q_count != '0) begin
        c_d        = C_REQ;
        swap_buf_d = (MODE == MODE_LATEST) ? q_newest : q_head;
        pop_n_d    = (MODE == MODE_LATEST) ? q_count : CW'(1);
      end
      C_REQ: if (swap_ack) begin
        c_d              = C_IDLE;
        st_d[front_q]    = ST_FREE;
        st_d[swap_buf_q] = ST_DISP;
        front_d          = swap_buf_q;
        fc_d             = fc_q + CNT_W'(1);
        q_pop_n          = pop_n_q;
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (CW'(i + 1) < pop_n_q) st_d[q_entries[i]] = ST_FREE;
        end
        dc_sum = {1'b0, dc_q} + SW'(pop_n_q) - SW'(1);
        dc_d   = dc_sum[CNT_W] ? '1 : dc_sum[CNT_W-1:0];
      end
      default: c_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q        <= P_REQ;
      c_q        <= C_IDLE;
      bg_buf_q   <= BW'(1);
      swap_buf_q <= '0;
      front_q    <= '0;
      pop_n_q    <= '0;
      sync_q     <= '0;
      ack_d_q    <= 1'b0;
      fc_q       <= '0;
      dc_q       <= '0;
      perr_q     <= 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) begin
        st_q[i] <= (i == 0) ? ST_DISP : ((i == 1) ? ST_DRAW : ST_FREE);
      end
    end else begin
      p_q        <= p_d;
      c_q        <= c_d;
      bg_buf_q   <= bg_buf_d;
      swap_buf_q <= swap_buf_d;
      front_q    <= front_d;
      pop_n_q    <= pop_n_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bg_done};
      ack_d_q    <= sync_q[SYNC_STAGES-1];
      fc_q       <= fc_d;
      dc_q       <= dc_d;
      perr_q     <= perr_d;
      st_q       <= st_d;
    end
  end

  assign swap         = (c_q == C_REQ);
  assign swap_buf     = swap_buf_q;
  assign front_buf    = front_q;
  assign bg_start     = (p_q == P_REQ);
  assign bg_buf       = bg_buf_q;
  assign bg_done_ack  = sync_q[SYNC_STAGES-1];
  assign frame_count  = fc_q;
  assign drop_count   = dc_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_multi_buffer_swap_ctrl.sv
// Randomized bench for multi_buffer_swap_ctrl: three configurations checked
// each cycle against an ownership/queue model of the swap rules.
module tb_multi_buffer_swap_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam int M_FREE  = 0;
  localparam int M_DRAW  = 1;
  localparam int M_READY = 2;
  localparam int M_DISP  = 3;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int NB   = (g == 0) ? 2 : ((g == 1) ? 3 : 4);
    localparam int MD   = (g == 2) ? 1 : 0;
    localparam int SS   = (g == 1) ? 3 : 2;
    localparam int CWID = (g == 2) ? 4 : 8;
    localparam int BW   = $clog2(NB);

    logic            reset, swap, swap_ack, bg_start, bg_start_ack;
    logic            bg_done, bg_done_ack, protocol_err;
    logic [BW-1:0]   swap_buf, front_buf, bg_buf;
    logic [CWID-1:0] frame_count, drop_count;

    multi_buffer_swap_ctrl #(
      .NUM_BUFS    (NB),
      .MODE        (MD),
      .SYNC_STAGES (SS),
      .CNT_W       (CWID)
    ) dut (
      .clock        (clock),
      .reset        (reset),
      .swap         (swap),
      .swap_buf     (swap_buf),
      .swap_ack     (swap_ack),
      .front_buf    (front_buf),
      .bg_start     (bg_start),
      .bg_buf       (bg_buf),
      .bg_start_ack (bg_start_ack),
      .bg_done      (bg_done),
      .bg_done_ack  (bg_done_ack),
      .frame_count  (frame_count),
      .drop_count   (drop_count),
      .protocol_err (protocol_err)
    );

    int    own [NB];
    int    rq [$];
    int    m_front, m_bg_buf, m_swap_buf, m_fc, m_dc;
    bit    m_bg_start, m_drawing, m_swap, m_perr, m_ackd;
    bit    dh [SS];
    bit    done_f;
    string pfx;

    int prod_phase, prod_wait, ack_pct;
    bit did_rst, spur_pend, spur_done;

    task automatic m_reset();
      for (int i = 0; i < NB; i++) own[i] = (i == 0) ? M_DISP : ((i == 1) ? M_DRAW : M_FREE);
      rq.delete();
      m_front = 0; m_bg_buf = 1; m_swap_buf = 0; m_fc = 0; m_dc = 0;
      m_bg_start = 1'b1; m_drawing = 1'b0; m_swap = 1'b0; m_perr = 1'b0; m_ackd = 1'b0;
      for (int i = 0; i < SS; i++) dh[i] = 1'b0;
    endtask

    // One clock edge of the swap rules, using the inputs present at that edge.
    task automatic m_step();
      int own0 [NB];
      int rq0 [$];
      bit draw0, done_now;
      int fidx, freed, b;
      if (reset) begin
        m_reset();
        return;
      end
      own0 = own;
      rq0 = rq;
      draw0 = m_drawing;
      done_now = dh[SS-1] && !m_ackd;
      m_ackd = dh[SS-1];
      for (int i = SS - 1; i > 0; i--) dh[i] = dh[i-1];
      dh[0] = bg_done;

      if (m_bg_start) begin
        if (bg_start_ack) begin
          m_bg_start = 1'b0;
          m_drawing  = 1'b1;
        end
      end else if (!draw0) begin
        fidx = -1;
        for (int i = NB - 1; i >= 0; i--) if (own0[i] == M_FREE) fidx = i;
        if (fidx >= 0) begin
          own[fidx] = M_DRAW;
          m_bg_buf = fidx;
          m_bg_start = 1'b1;
        end
      end
      if (done_now) begin
        if (draw0) begin
          own[m_bg_buf] = M_READY;
          rq.push_back(m_bg_buf);
          m_drawing = 1'b0;
        end else begin
          m_perr = 1'b1;
        end
      end

      if (m_swap) begin
        if (swap_ack) begin
          own[m_front] = M_FREE;
          m_front = m_swap_buf;
          own[m_front] = M_DISP;
          m_fc = (m_fc + 1) % (1 << CWID);
          m_swap = 1'b0;
          freed = 0;
          while (rq.size() > 0 && rq[0] != m_swap_buf) begin
            b = rq.pop_front();
            own[b] = M_FREE;
            freed++;
          end
          if (rq.size() > 0) void'(rq.pop_front());
          m_dc = (m_dc + freed > (1 << CWID) - 1) ? (1 << CWID) - 1 : m_dc + freed;
        end
      end else if (rq0.size() > 0) begin
        m_swap = 1'b1;
        m_swap_buf = (MD == 1) ? rq0[rq0.size()-1] : rq0[0];
      end
    endtask

    task automatic compare();
      check({pfx, "swap"},         32'(swap),         32'(m_swap));
      check({pfx, "swap_buf"},     32'(swap_buf),     32'(m_swap_buf));
      check({pfx, "front_buf"},    32'(front_buf),    32'(m_front));
      check({pfx, "bg_start"},     32'(bg_start),     32'(m_bg_start));
      check({pfx, "bg_buf"},       32'(bg_buf),       32'(m_bg_buf));
      check({pfx, "bg_done_ack"},  32'(bg_done_ack),  32'(dh[SS-1]));
      check({pfx, "frame_count"},  32'(frame_count),  32'(m_fc));
      check({pfx, "drop_count"},   32'(drop_count),   32'(m_dc));
      check({pfx, "protocol_err"}, 32'(protocol_err), 32'(m_perr));
    endtask

    task automatic check_rst();
      check({pfx, "rst_swap"},     32'(swap),         32'd0);
      check({pfx, "rst_swap_buf"}, 32'(swap_buf),     32'd0);
      check({pfx, "rst_front"},    32'(front_buf),    32'd0);
      check({pfx, "rst_bg_start"}, 32'(bg_start),     32'd1);
      check({pfx, "rst_bg_buf"},   32'(bg_buf),       32'd1);
      check({pfx, "rst_done_ack"}, 32'(bg_done_ack),  32'd0);
      check({pfx, "rst_frames"},   32'(frame_count),  32'd0);
      check({pfx, "rst_drops"},    32'(drop_count),   32'd0);
      check({pfx, "rst_perr"},     32'(protocol_err), 32'd0);
    endtask

    initial begin
      pfx = $sformatf("i%0d.", g);
      done_f = 1'b0;
      reset = 1'b1; swap_ack = 1'b0; bg_start_ack = 1'b0; bg_done = 1'b0;
      prod_phase = 0; prod_wait = 0; ack_pct = 30;
      did_rst = 1'b0; spur_pend = 1'b0; spur_done = 1'b0;
      m_reset();
      repeat (3) @(posedge clock);
      #1;
      check_rst();
      reset = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(posedge clock);
        #1;
        m_step();
        compare();
        if (reset) begin
          check_rst();
          reset = 1'b0;
        end else if (!did_rst && ((cyc > 1000 && m_drawing && m_swap) || cyc == 1900)) begin
          reset = 1'b1; did_rst = 1'b1;
          bg_done = 1'b0; swap_ack = 1'b0; bg_start_ack = 1'b0;
          prod_phase = 0;
          continue;
        end
        if (cyc == 2000) spur_pend = 1'b1;
        if (cyc % 200 == 0) ack_pct = $urandom_range(3, 70);

        bg_start_ack = 1'b0;
        case (prod_phase)
          0: begin
            if (spur_pend) begin
              bg_done = 1'b1; prod_phase = 2; spur_pend = 1'b0; spur_done = 1'b1;
            end else if (bg_start && $urandom_range(0, 2) != 0) begin
              bg_start_ack = 1'b1; prod_phase = 1; prod_wait = $urandom_range(0, 6);
            end
          end
          1: begin
            if (prod_wait == 0) begin
              bg_done = 1'b1; prod_phase = 2;
            end else begin
              prod_wait--;
            end
          end
          2: if (bg_done_ack) begin
            bg_done = 1'b0; prod_phase = 3;
          end
          default: if (!bg_done_ack) prod_phase = 0;
        endcase
        swap_ack = swap && ($urandom_range(0, 99) < ack_pct);
      end
      check({pfx, "perr_end"}, 32'(protocol_err), 32'(spur_done));
      done_f = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].done_f && g_inst[1].done_f && g_inst[2].done_f) && t < 20000) begin
      @(posedge clock);
      t++;
    end
    check("all_done", {29'd0, g_inst[2].done_f, g_inst[1].done_f, g_inst[0].done_f}, 32'h7);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
